// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory-stage MMU port arbiter: requester ids,
// outstanding-queue entries and MMU access size encodings.
package mem_port_arb_pkg;

    typedef enum logic {
        PIPE0 = 1'b0,
        PIPE1 = 1'b1
    } mem_src_t;

    typedef struct packed {
        mem_src_t src;
        logic     discard;
    } out_entry_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic mem_src_t other_pipe(input mem_src_t s);
        return (s == PIPE0) ? PIPE1 : PIPE0;
    endfunction

endpackage

// File: rtl/mem_src_fifo.sv
// In-order queue of outstanding MMU requests: remembers which pipe issued
// each request and whether its response must be thrown away.
module mem_src_fifo
    import mem_port_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  out_entry_t   push_entry,
    input  logic         pop,
    input  logic         set_discard,
    output out_entry_t   head,
    output logic         full,
    output logic         empty,
    output logic [PW:0]  count
);

    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    out_entry_t        mem_q [DEPTH];
    out_entry_t        mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Broadcast discard is applied before the push so a new entry written in
    // the same cycle still picks up the flush.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (set_discard) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i].discard = 1'b1;
            end
        end
        if (do_push) begin
            mem_d[wr_ptr_q].src     = push_entry.src;
            mem_d[wr_ptr_q].discard = push_entry.discard | set_discard;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shares the MMU data-side port between the two memory-stage pipes and
// routes in-order MMU responses back to the pipe that issued each request.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit PRIO_PIPE0      = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0]       req_we,
    input  logic [1:0][1:0]  req_size,
    input  logic [1:0][3:0]  req_wstrb,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       req_addr_ok,
    output logic [1:0]       req_data_ok,
    output logic [1:0][31:0] req_rdata,
    output logic             mmu_valid,
    output logic [31:0]      mmu_addr,
    output logic             mmu_we,
    output logic [1:0]       mmu_size,
    output logic [3:0]       mmu_wstrb,
    output logic [31:0]      mmu_wdata,
    input  logic             mmu_addr_ok,
    input  logic             mmu_data_ok,
    input  logic [31:0]      mmu_rdata,
    output logic             busy
);

    localparam int PW = $clog2(MAX_OUTSTANDING);

    logic        lock_q, lock_d;
    mem_src_t    lock_src_q, lock_src_d;
    mem_src_t    rr_q, rr_d;
    mem_src_t    grant;
    logic        accept;
    logic        forward;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [PW:0] fifo_count;
    out_entry_t  fifo_head;
    out_entry_t  push_entry;

    always_comb begin
        grant = PIPE0;
        if (lock_q) begin
            grant = lock_src_q;
        end else begin
            case (req_valid)
                2'b10:   grant = PIPE1;
                2'b11:   grant = PRIO_PIPE0 ? PIPE0 : rr_q;
                default: grant = PIPE0;
            endcase
        end
    end

    // mmu_valid is gated by resetn so the port is quiet the moment reset asserts.
    assign mmu_valid  = resetn && req_valid[grant] && !fifo_full && !flush;
    assign accept     = mmu_valid && mmu_addr_ok;
    assign fifo_pop   = mmu_data_ok && !fifo_empty;
    assign forward    = fifo_pop && !fifo_head.discard && !flush;
    assign push_entry = '{src: grant, discard: 1'b0};
    assign busy       = (fifo_count != '0);

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        rr_d       = rr_q;
        if (flush || accept) begin
            lock_d = 1'b0;
        end else if (mmu_valid && !mmu_addr_ok) begin
            lock_d     = 1'b1;
            lock_src_d = grant;
        end else if (lock_q && !req_valid[lock_src_q]) begin
            lock_d = 1'b0;
        end
        if (accept) begin
            rr_d = other_pipe(grant);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q     <= 1'b0;
            lock_src_q <= PIPE0;
            rr_q       <= PIPE0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            rr_q       <= rr_d;
        end
    end

    always_comb begin
        mmu_addr    = req_addr[grant];
        mmu_we      = req_we[grant];
        mmu_size    = req_size[grant];
        mmu_wstrb   = req_wstrb[grant];
        mmu_wdata   = req_wdata[grant];
        req_addr_ok = '0;
        req_addr_ok[grant] = accept;
        req_data_ok = '0;
        req_rdata   = '0;
        if (forward) begin
            req_data_ok[fifo_head.src] = 1'b1;
            req_rdata[fifo_head.src]   = mmu_rdata;
        end
    end

    mem_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (accept),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .set_discard (flush),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    // A response with nothing outstanding means the MMU broke ordering.
    no_orphan_data_ok: assert property (
        @(posedge clk) disable iff (!resetn) !(mmu_data_ok && fifo_empty)
    );

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: arbitration, lock, back-pressure, flush
// and reset, each scenario checked against hand-computed values.
module tb_mem_port_arb;
    import mem_port_arb_pkg::*;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_addr;
    logic [1:0]       req_we;
    logic [1:0][1:0]  req_size;
    logic [1:0][3:0]  req_wstrb;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_addr_ok;
    logic [1:0]       req_data_ok;
    logic [1:0][31:0] req_rdata;
    logic             mmu_valid;
    logic [31:0]      mmu_addr;
    logic             mmu_we;
    logic [1:0]       mmu_size;
    logic [3:0]       mmu_wstrb;
    logic [31:0]      mmu_wdata;
    logic             mmu_addr_ok;
    logic             mmu_data_ok;
    logic [31:0]      mmu_rdata;
    logic             busy;

    int checks = 0;
    int errors = 0;

    mem_port_arb #(
        .MAX_OUTSTANDING (2),
        .PRIO_PIPE0      (1'b1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_wstrb   (req_wstrb),
        .req_wdata   (req_wdata),
        .req_addr_ok (req_addr_ok),
        .req_data_ok (req_data_ok),
        .req_rdata   (req_rdata),
        .mmu_valid   (mmu_valid),
        .mmu_addr    (mmu_addr),
        .mmu_we      (mmu_we),
        .mmu_size    (mmu_size),
        .mmu_wstrb   (mmu_wstrb),
        .mmu_wdata   (mmu_wdata),
        .mmu_addr_ok (mmu_addr_ok),
        .mmu_data_ok (mmu_data_ok),
        .mmu_rdata   (mmu_rdata),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic idle();
        flush       = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_we      = '0;
        req_size    = '0;
        req_wstrb   = '0;
        req_wdata   = '0;
        mmu_addr_ok = 1'b0;
        mmu_data_ok = 1'b0;
        mmu_rdata   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        req_valid   = 2'b01;
        mmu_data_ok = 1'b1;
        #2;
        checks++;
        if (mmu_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mmu_valid got %b want 0", mmu_valid); end
        checks++;
        if (req_addr_ok !== 2'b00) begin errors++; $display("[TB] FAIL reset_addr_ok got %b want 00", req_addr_ok); end
        checks++;
        if (req_data_ok !== 2'b00) begin errors++; $display("[TB] FAIL reset_data_ok got %b want 00", req_data_ok); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (req_rdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", req_rdata); end
        idle();
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_load();
        idle();
        req_valid    = 2'b01;
        req_addr[0]  = 32'h1C00_0100;
        req_size[0]  = SIZE_WORD;
        req_wstrb[0] = 4'hF;
        mmu_addr_ok  = 1'b1;
        #2;
        checks++;
        if (req_addr_ok !== 2'b01) begin errors++; $display("[TB] FAIL single_addr_ok got %b want 01", req_addr_ok); end
        checks++;
        if (mmu_addr !== 32'h1C00_0100) begin errors++; $display("[TB] FAIL single_mmu_addr got %h want 1c000100", mmu_addr); end
        checks++;
        if (mmu_size !== SIZE_WORD) begin errors++; $display("[TB] FAIL single_mmu_size got %0d want 2", mmu_size); end
        next_cycle();
        idle();
        #2;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", busy); end
        checks++;
        if (req_data_ok !== 2'b00) begin errors++; $display("[TB] FAIL single_early_data_ok got %b want 00", req_data_ok); end
        next_cycle();
        idle();
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'hDEAD_BEEF;
        #2;
        checks++;
        if (req_data_ok !== 2'b01) begin errors++; $display("[TB] FAIL single_data_ok got %b want 01", req_data_ok); end
        checks++;
        if (req_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_rdata0 got %h want deadbeef", req_rdata[0]); end
        checks++;
        if (req_rdata[1] !== 32'h0) begin errors++; $display("[TB] FAIL single_rdata1 got %h want 0", req_rdata[1]); end
        next_cycle();
        idle();
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_priority();
        idle();
        req_valid   = 2'b11;
        req_addr[0] = 32'h0000_1000;
        req_addr[1] = 32'h0000_2000;
        mmu_addr_ok = 1'b1;
        #2;
        checks++;
        if (req_addr_ok !== 2'b01) begin errors++; $display("[TB] FAIL prio_grant0 got %b want 01", req_addr_ok); end
        checks++;
        if (mmu_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL prio_addr0 got %h want 00001000", mmu_addr); end
        next_cycle();
        req_valid = 2'b10;
        #2;
        checks++;
        if (req_addr_ok !== 2'b10) begin errors++; $display("[TB] FAIL prio_grant1 got %b want 10", req_addr_ok); end
        checks++;
        if (mmu_addr !== 32'h0000_2000) begin errors++; $display("[TB] FAIL prio_addr1 got %h want 00002000", mmu_addr); end
        next_cycle();
        idle();
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'h11;
        #2;
        checks++;
        if (req_data_ok !== 2'b01 || req_rdata[0] !== 32'h11) begin
            errors++; $display("[TB] FAIL prio_resp0 got ok=%b rdata=%h want ok=01 rdata=11", req_data_ok, req_rdata[0]);
        end
        next_cycle();
        mmu_rdata = 32'h22;
        #2;
        checks++;
        if (req_data_ok !== 2'b10 || req_rdata[1] !== 32'h22) begin
            errors++; $display("[TB] FAIL prio_resp1 got ok=%b rdata=%h want ok=10 rdata=22", req_data_ok, req_rdata[1]);
        end
        next_cycle();
        idle();
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL prio_busy_end got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_lock();
        for (int i = 0; i < 3; i++) begin
            idle();
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_addr[0]  = 32'h1C00_0200;
            req_wdata[0] = 32'hCAFE_F00D;
            req_wstrb[0] = 4'hF;
            if (i >= 1) begin
                req_valid[1] = 1'b1;
                req_addr[1]  = 32'h1C00_0300;
                req_wdata[1] = 32'h1234_5678;
            end
            #2;
            checks++;
            if (mmu_valid !== 1'b1 || req_addr_ok !== 2'b00) begin
                errors++; $display("[TB] FAIL lock_wait%0d got valid=%b addr_ok=%b want valid=1 addr_ok=00", i, mmu_valid, req_addr_ok);
            end
            checks++;
            if (mmu_addr !== 32'h1C00_0200 || mmu_wdata !== 32'hCAFE_F00D) begin
                errors++; $display("[TB] FAIL lock_payload%0d got addr=%h wdata=%h want addr=1c000200 wdata=cafef00d", i, mmu_addr, mmu_wdata);
            end
            next_cycle();
        end
        mmu_addr_ok = 1'b1;
        #2;
        checks++;
        if (req_addr_ok !== 2'b01 || mmu_we !== 1'b1) begin
            errors++; $display("[TB] FAIL lock_accept got addr_ok=%b we=%b want addr_ok=01 we=1", req_addr_ok, mmu_we);
        end
        next_cycle();
        req_valid[0] = 1'b0;
        #2;
        checks++;
        if (req_addr_ok !== 2'b10 || mmu_addr !== 32'h1C00_0300) begin
            errors++; $display("[TB] FAIL lock_next got addr_ok=%b addr=%h want addr_ok=10 addr=1c000300", req_addr_ok, mmu_addr);
        end
        next_cycle();
        idle();
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'hA5;
        #2;
        checks++;
        if (req_data_ok !== 2'b01) begin errors++; $display("[TB] FAIL lock_resp0 got %b want 01", req_data_ok); end
        next_cycle();
        mmu_rdata = 32'h5A;
        #2;
        checks++;
        if (req_data_ok !== 2'b10 || req_rdata[1] !== 32'h5A) begin
            errors++; $display("[TB] FAIL lock_resp1 got ok=%b rdata=%h want ok=10 rdata=5a", req_data_ok, req_rdata[1]);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_back_to_back_full();
        idle();
        req_valid   = 2'b01;
        req_addr[0] = 32'h0000_3000;
        mmu_addr_ok = 1'b1;
        next_cycle();
        req_valid   = 2'b10;
        req_addr[1] = 32'h0000_4000;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            req_valid   = 2'b01;
            req_addr[0] = 32'h0000_5000;
            #2;
            checks++;
            if (mmu_valid !== 1'b0 || req_addr_ok !== 2'b00) begin
                errors++; $display("[TB] FAIL full_block%0d got valid=%b addr_ok=%b want 0/00", i, mmu_valid, req_addr_ok);
            end
            next_cycle();
        end
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'h33;
        #2;
        checks++;
        if (mmu_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_cycle_valid got %b want 0", mmu_valid); end
        checks++;
        if (req_data_ok !== 2'b01 || req_rdata[0] !== 32'h33) begin
            errors++; $display("[TB] FAIL full_resp0 got ok=%b rdata=%h want ok=01 rdata=33", req_data_ok, req_rdata[0]);
        end
        next_cycle();
        mmu_data_ok = 1'b0;
        mmu_rdata   = 32'h0;
        #2;
        checks++;
        if (mmu_valid !== 1'b1 || req_addr_ok !== 2'b01) begin
            errors++; $display("[TB] FAIL full_admit got valid=%b addr_ok=%b want 1/01", mmu_valid, req_addr_ok);
        end
        next_cycle();
        idle();
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'h44;
        #2;
        checks++;
        if (req_data_ok !== 2'b10 || req_rdata[1] !== 32'h44) begin
            errors++; $display("[TB] FAIL full_resp1 got ok=%b rdata=%h want ok=10 rdata=44", req_data_ok, req_rdata[1]);
        end
        next_cycle();
        mmu_rdata = 32'h55;
        #2;
        checks++;
        if (req_data_ok !== 2'b01 || req_rdata[0] !== 32'h55) begin
            errors++; $display("[TB] FAIL full_resp2 got ok=%b rdata=%h want ok=01 rdata=55", req_data_ok, req_rdata[0]);
        end
        next_cycle();
        idle();
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_end got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_flush();
        idle();
        req_valid   = 2'b01;
        mmu_addr_ok = 1'b1;
        next_cycle();
        req_valid = 2'b10;
        next_cycle();
        req_valid   = 2'b01;
        flush       = 1'b1;
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'h88;
        #2;
        checks++;
        if (req_data_ok !== 2'b00) begin errors++; $display("[TB] FAIL flush_drop0 got %b want 00", req_data_ok); end
        checks++;
        if (mmu_valid !== 1'b0 || req_addr_ok !== 2'b00) begin
            errors++; $display("[TB] FAIL flush_no_push got valid=%b addr_ok=%b want 0/00", mmu_valid, req_addr_ok);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy got %b want 1", busy); end
        next_cycle();
        idle();
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'h99;
        #2;
        checks++;
        if (req_data_ok !== 2'b00 || req_rdata !== 64'h0) begin
            errors++; $display("[TB] FAIL flush_drop1 got ok=%b rdata=%h want ok=00 rdata=0", req_data_ok, req_rdata);
        end
        next_cycle();
        idle();
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy_end got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        idle();
        req_valid   = 2'b01;
        mmu_addr_ok = 1'b1;
        next_cycle();
        req_valid   = 2'b01;
        mmu_addr_ok = 1'b0;
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'h66;
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mmu_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_state got busy=%b valid=%b want 0/0", busy, mmu_valid);
        end
        checks++;
        if (req_data_ok !== 2'b00 || req_addr_ok !== 2'b00 || req_rdata !== 64'h0) begin
            errors++; $display("[TB] FAIL rstmid_outputs got data_ok=%b addr_ok=%b rdata=%h want all 0", req_data_ok, req_addr_ok, req_rdata);
        end
        next_cycle();
        resetn = 1'b1;
        idle();
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_empty got %b want 0", busy); end
        next_cycle();
        req_valid   = 2'b10;
        req_addr[1] = 32'h0000_7000;
        mmu_addr_ok = 1'b1;
        #2;
        checks++;
        if (req_addr_ok !== 2'b10) begin errors++; $display("[TB] FAIL rstmid_accept got %b want 10", req_addr_ok); end
        next_cycle();
        idle();
        mmu_data_ok = 1'b1;
        mmu_rdata   = 32'h77;
        #2;
        checks++;
        if (req_data_ok !== 2'b10 || req_rdata[1] !== 32'h77) begin
            errors++; $display("[TB] FAIL rstmid_resp got ok=%b rdata=%h want ok=10 rdata=77", req_data_ok, req_rdata[1]);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_priority();
        test_lock();
        test_back_to_back_full();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
